reglk_req_bridge: RTL and testbench

Request front-end for the register-lock block. It accepts width-tagged read/write transactions from a valid/ready master and performs alignment checks and byte-lane steering. It then drives the register-lock block's single-cycle access port (`write_enable`, `mem_width`, `addr`, `write_data`) and captures `read_data` into a valid/ready response. It sits directly upstream of the register-lock wrapper and is the only agent driving that port.

---
 rtl/reglk_req_bridge_pkg.sv | 25 ++
 rtl/reglk_req_bridge_if.sv | 26 ++
 rtl/reglk_req_bridge_lane_align.sv | 39 +++
 rtl/reglk_req_bridge.sv | 109 ++++++++++
 tb/tb_reglk_req_bridge.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reglk_req_bridge_pkg.sv
// Shared types and constants for the register-lock request bridge.
package reglk_pkg;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  localparam logic [2:0] WIDTH_BYTE = 3'd0;
  localparam logic [2:0] WIDTH_HALF = 3'd1;
  localparam logic [2:0] WIDTH_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [2:0]            width;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/reglk_req_bridge_if.sv
// Request/response handshake bundle between a master and the bridge.
interface reglk_req_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_width;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_width, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_width, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/reglk_req_bridge_lane_align.sv
// Combinational alignment check, write-lane replication and read-lane extraction.
module reglk_lane_align
  import reglk_pkg::*;
(
  input  logic [2:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  // Decode width into legality and lane steering; widths 3-7 are illegal.
  always_comb begin
    legal       = 1'b0;
    wdata_lanes = '0;
    rdata_ext   = '0;
    case (width)
      WIDTH_BYTE: begin
        legal       = 1'b1;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {24'h0, rdata[{addr_lo, 3'b000} +: 8]};
      end
      WIDTH_HALF: begin
        legal       = ~addr_lo[0];
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {16'h0, rdata[{addr_lo[1], 4'b0000} +: 16]};
      end
      WIDTH_WORD: begin
        legal       = (addr_lo == 2'b00);
        wdata_lanes = wdata;
        rdata_ext   = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reglk_req_bridge.sv
// Request front-end: one transaction at a time onto the register-lock access port.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | ready for a request; latch it on req_valid
// ST_ACCESS | drive the access port for one cycle (write strobe here)
// ST_WAIT   | hold address for a read; capture read_data at cycle end
// ST_RESP   | present the response until rsp_ready
module reglk_req_bridge
  import reglk_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  reglk_req_bridge_if.slave bus,
  output logic              write_enable,
  output logic [2:0]        mem_width,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  state_t      state_q, state_d;
  req_t        req_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        idle;
  logic [2:0]  al_width;
  logic [1:0]  al_addr_lo;
  logic        al_legal;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  // The checker looks at the live request while idle and at the latched one afterwards.
  assign idle       = (state_q == ST_IDLE);
  assign al_width   = idle ? bus.req_width     : req_q.width;
  assign al_addr_lo = idle ? bus.req_addr[1:0] : req_q.addr[1:0];

  reglk_lane_align u_align (
    .width       (al_width),
    .addr_lo     (al_addr_lo),
    .wdata       (req_q.wdata),
    .rdata       (read_data),
    .legal       (al_legal),
    .wdata_lanes (al_wdata),
    .rdata_ext   (al_rdata)
  );

  // Next-state and all outputs decoded from the current state; everything defaults to 0.
  always_comb begin
    state_d       = state_q;
    write_enable  = 1'b0;
    mem_width     = '0;
    addr          = '0;
    write_data    = '0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = al_legal ? ST_ACCESS : ST_RESP;
      end
      ST_ACCESS: begin
        write_enable = req_q.write;
        mem_width    = req_q.width;
        addr         = req_q.addr;
        write_data   = al_wdata;
        state_d      = req_q.write ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        mem_width = req_q.width;
        addr      = req_q.addr;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        bus.rsp_rdata = rdata_q;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request and response registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (idle && bus.req_valid) begin
        req_q   <= '{write: bus.req_write, width: bus.req_width,
                     addr: bus.req_addr, wdata: bus.req_wdata};
        err_q   <= ~al_legal;
        rdata_q <= '0;
      end
      if (state_q == ST_WAIT) rdata_q <= al_rdata;
    end
  end

endmodule

// File: tb/tb_reglk_req_bridge.sv
// Directed and random bench for reglk_req_bridge against a byte-memory model.
module tb_reglk_req_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_enable;
  logic [2:0]  mem_width;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  always #5 clk = ~clk;

  reglk_req_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  reglk_req_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .write_enable (write_enable),
    .mem_width    (mem_width),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  function automatic logic [7:0] seed_byte(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // Downstream register-lock stand-in: byte memory, registered read one cycle after addr.
  logic [7:0] dmem [0:1023];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= seed_byte(i);
    end else if (write_enable && !rst) begin
      case (mem_width)
        3'd0: dmem[addr[9:0]] <= write_data[{addr[1:0], 3'b000} +: 8];
        3'd1: begin
          dmem[addr[9:0]]         <= write_data[{addr[1], 4'b0000} +: 8];
          dmem[addr[9:0] + 10'd1] <= write_data[{addr[1], 4'b1000} +: 8];
        end
        default: begin
          dmem[addr[9:0]]         <= write_data[7:0];
          dmem[addr[9:0] + 10'd1] <= write_data[15:8];
          dmem[addr[9:0] + 10'd2] <= write_data[23:16];
          dmem[addr[9:0] + 10'd3] <= write_data[31:24];
        end
      endcase
    end
    read_data <= {dmem[{addr[9:2], 2'b11}], dmem[{addr[9:2], 2'b10}],
                  dmem[{addr[9:2], 2'b01}], dmem[{addr[9:2], 2'b00}]};
  end

  // Reference byte memory, updated when a legal write is issued.
  logic [7:0] mmem [0:1023];

  logic        chk_en;
  logic        exp_req_ready, exp_rsp_valid, exp_rsp_err, exp_we, exp_chk_wd;
  logic [31:0] exp_rdata, exp_addr, exp_wd;
  logic [2:0]  exp_mw;
  logic        pin_r_en, pin_w_en;
  logic [31:0] pin_r, pin_w;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, DUT outputs against the expected timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_req_ready));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp_valid));
      if (exp_rsp_valid) begin
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_rsp_err));
        chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
        if (pin_r_en) chk("rsp_rdata_literal", bus.rsp_rdata, pin_r);
      end
      chk("write_enable", 32'(write_enable), 32'(exp_we));
      chk("mem_width", 32'(mem_width), 32'(exp_mw));
      chk("addr", addr, exp_addr);
      if (exp_chk_wd) chk("write_data", write_data, exp_wd);
      if (pin_w_en) chk("write_data_literal", write_data, pin_w);
    end
  end

  task automatic set_quiet(input logic ready);
    exp_req_ready = ready;
    exp_rsp_valid = 1'b0;
    exp_rsp_err   = 1'b0;
    exp_rdata     = '0;
    exp_we        = 1'b0;
    exp_mw        = '0;
    exp_addr      = '0;
    exp_wd        = '0;
    exp_chk_wd    = 1'b1;
    pin_r_en      = 1'b0;
    pin_w_en      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction, started in an IDLE cycle (posedge+1); returns in the next IDLE cycle.
  task automatic xact(input logic w, input logic [2:0] wd, input logic [31:0] a,
                      input logic [31:0] d, input int stall,
                      input logic pr_en, input logic [31:0] pr,
                      input logic pw_en, input logic [31:0] pw);
    logic        legal;
    logic [31:0] lanes, rv;
    int          ix;
    ix    = int'(a[9:0]);
    legal = (wd == 3'd0) || (wd == 3'd1 && !a[0]) || (wd == 3'd2 && a[1:0] == 2'b00);
    lanes = (wd == 3'd0) ? {4{d[7:0]}} : (wd == 3'd1) ? {2{d[15:0]}} : d;
    rv    = '0;
    if (legal && !w) begin
      if (wd == 3'd0)      rv = {24'h0, mmem[ix]};
      else if (wd == 3'd1) rv = {16'h0, mmem[ix+1], mmem[ix]};
      else                 rv = {mmem[ix+3], mmem[ix+2], mmem[ix+1], mmem[ix]};
    end
    if (legal && w) begin
      mmem[ix] = d[7:0];
      if (wd != 3'd0) mmem[ix+1] = d[15:8];
      if (wd == 3'd2) begin
        mmem[ix+2] = d[23:16];
        mmem[ix+3] = d[31:24];
      end
    end
    set_quiet(1'b1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_width = wd;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_width = 3'($urandom);
    bus.req_wdata = $urandom;
    if (legal) begin
      set_quiet(1'b0);
      exp_we   = w;
      exp_mw   = wd;
      exp_addr = a;
      exp_wd   = lanes;
      pin_w_en = pw_en;
      pin_w    = pw;
      tick();
      if (!w) begin
        set_quiet(1'b0);
        exp_mw     = wd;
        exp_addr   = a;
        exp_chk_wd = 1'b0;
        tick();
      end
    end
    for (int s = 0; s <= stall; s++) begin
      set_quiet(1'b0);
      exp_rsp_valid = 1'b1;
      exp_rsp_err   = !legal;
      exp_rdata     = rv;
      pin_r_en      = pr_en;
      pin_r         = pr;
      bus.rsp_ready = (s == stall);
      tick();
    end
    set_quiet(1'b1);
    bus.rsp_ready = 1'b1;
  endtask

  initial begin
    logic        rw;
    logic [2:0]  rwd;
    logic [31:0] ra;
    chk_en        = 1'b0;
    rst           = 1'b1;
    mem_init      = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_width = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mmem[i] = seed_byte(i);
    set_quiet(1'b1);
    tick();
    chk_en = 1'b1;
    tick();
    rst      = 1'b0;
    mem_init = 1'b0;
    tick();

    xact(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
    xact(1'b0, 3'd2, 32'h100, 32'h0, 0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);

    xact(1'b1, 3'd2, 32'h100, 32'h44332211, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    xact(1'b0, 3'd0, 32'h102, 32'h0, 0, 1'b1, 32'h00000033, 1'b0, 32'h0);
    xact(1'b0, 3'd1, 32'h102, 32'h0, 0, 1'b1, 32'h00004433, 1'b0, 32'h0);
    xact(1'b1, 3'd0, 32'h101, 32'h000000A5, 0, 1'b0, 32'h0, 1'b1, 32'hA5A5A5A5);

    xact(1'b0, 3'd1, 32'h101, 32'h0, 0, 1'b1, 32'h0, 1'b0, 32'h0);
    xact(1'b1, 3'd2, 32'h102, 32'h11112222, 0, 1'b1, 32'h0, 1'b0, 32'h0);
    xact(1'b0, 3'd5, 32'h100, 32'h0, 0, 1'b1, 32'h0, 1'b0, 32'h0);

    xact(1'b0, 3'd2, 32'h100, 32'h0, 10, 1'b1, 32'h4433A511, 1'b0, 32'h0);

    // Reset lands while a write is in its ACCESS cycle.
    set_quiet(1'b1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_width = 3'd2;
    bus.req_addr  = 32'h200;
    bus.req_wdata = 32'h12345678;
    tick();
    bus.req_valid = 1'b0;
    set_quiet(1'b0);
    exp_we   = 1'b1;
    exp_mw   = 3'd2;
    exp_addr = 32'h200;
    exp_wd   = 32'h12345678;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    set_quiet(1'b1);
    xact(1'b0, 3'd2, 32'h100, 32'h0, 0, 1'b1, 32'h4433A511, 1'b0, 32'h0);
    xact(1'b0, 3'd2, 32'h200, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);

    for (int n = 0; n < 200; n++) begin
      rw  = 1'($urandom_range(0, 1));
      rwd = 3'($urandom_range(0, 2));
      ra  = 32'($urandom_range(0, 1023));
      if (rwd == 3'd1) ra[0] = 1'b0;
      if (rwd == 3'd2) ra[1:0] = 2'b00;
      xact(rw, rwd, ra, $urandom, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    end

    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
